// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data memory,
// data first, with a starvation counter that forces a pending fetch through.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;
  localparam logic [3:0] MAX = 4'(STARVE_MAX);
  state_t     r_state, w_next;
  logic [3:0] r_starve, w_starve_next;
  logic       r_err, w_err_next;
  logic       w_dreq, w_ireq, w_done, w_error;
  assign w_dreq  = dREN | dWEN;
  assign w_ireq  = iREN;
  assign w_done  = ramstate[1];
  assign w_error = &ramstate;
  assign err     = r_err;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_starve <= w_starve_next;
      r_err    <= w_err_next;
    end
  // RAM outputs are pure functions of state and live requester inputs, so they
  // stay stable for as long as the requester holds its request during BUSY.
  always_comb begin
    w_next        = r_state;
    w_starve_next = r_starve;
    w_err_next    = r_err;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    iload         = '0;
    dload         = '0;
    iwait         = w_ireq;
    dwait         = w_dreq;
    gnt_i         = r_state == IGNT;
    gnt_d         = r_state == DGNT;
    case (r_state)
      IDLE: w_next = (w_dreq && r_starve < MAX) ? DGNT : w_ireq ? IGNT : w_dreq ? DGNT : IDLE;
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = w_dreq & ~w_done;
        if (!w_dreq) w_next = IDLE;
        else if (w_done) begin
          w_next        = IDLE;
          w_starve_next = !iREN ? '0 : (r_starve < MAX) ? r_starve + 4'd1 : MAX;
          w_err_next    = r_err | w_error;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = w_ireq & ~w_done;
        if (!w_ireq) w_next = IDLE;
        else if (w_done) begin
          w_next        = IDLE;
          w_starve_next = '0;
          w_err_next    = r_err | w_error;
        end
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed protocol checks plus a randomized scoreboard run
// against a word-addressed RAM model.
module tb_mem_arbiter;
  localparam int SMAX = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic        CLK = 0, RST = 0, iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ram_ld = 0;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, gnt_i, gnt_d, err;
  logic [1:0]  ramstate, rs_dir = BUSY, rs_auto = BUSY;
  logic [31:0] mem [64];
  logic [63:0] wv = '0;
  logic [31:0] refmem [64];
  bit          rnd = 0;
  int          n_chk = 0, n_err = 0;
  int          m_cnt = 0;
  bit          p_idle = 1, p_ireq = 0;
  typedef struct {bit we; logic [31:0] addr; logic [31:0] data;} exp_t;
  exp_t dq[$], iq[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .gnt_i(gnt_i), .gnt_d(gnt_d), .err(err));

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  always #5 CLK = ~CLK;
  assign ramstate = rnd ? rs_auto : rs_dir;
  assign ramload  = !rnd ? ram_ld : wv[ramaddr[7:2]] ? mem[ramaddr[7:2]] : init_val(int'(ramaddr[7:2]));
  always @(posedge CLK) begin
    rs_auto <= (($urandom_range(0, 3)) == 0) ? FREE : ($urandom_range(0, 2) == 0) ? BUSY : ACCESS;
    if (rnd && ramWEN && ramstate[1]) begin
      mem[ramaddr[7:2]] <= ramstore;
      wv[ramaddr[7:2]]  <= 1'b1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic smp(); @(negedge CLK); endtask
  task automatic count_d(output int n);
    int nd = 0;
    n = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (gnt_d) nd++;
      if (gnt_i) begin n = nd; break; end
    end
  endtask
  task automatic timeout(string nm);
    n_chk++; n_err++;
    $display("FAIL %s: no completion within bound", nm);
  endtask

  task automatic drv_d();
    int idx; bit we, both; logic [31:0] data; bit ok;
    for (int i = 0; i < 64; i++) refmem[i] = init_val(i);
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      idx = $urandom_range(32, 63); we = 1'($urandom_range(0, 1));
      both = $urandom_range(0, 3) == 0; data = $urandom;
      if (we) refmem[idx] = data;
      dq.push_back('{we, 32'(idx * 4), we ? data : refmem[idx]});
      daddr = 32'(idx * 4); dstore = data; dWEN = we; dREN = !we || both;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin @(negedge CLK); ok = !dwait; end
      if (!ok) timeout("d_txn");
      tick(); dWEN = 0; dREN = 0;
    end
  endtask

  task automatic drv_i();
    int idx; bit ok;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      idx = $urandom_range(0, 31);
      iq.push_back('{1'b0, 32'(idx * 4), init_val(idx)});
      iaddr = 32'(idx * 4); iREN = 1;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin @(negedge CLK); ok = !iwait; end
      if (!ok) timeout("i_txn");
      tick(); iREN = 0;
    end
  endtask

  // Scoreboard and fetch-starvation model, evaluated once per cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (rnd && !RST) begin
      if (gnt_d && !dwait) begin
        if (dq.size() == 0) timeout("d_unexpected");
        else begin
          e = dq.pop_front();
          chk("d_we", 32'(ramWEN), 32'(e.we));
          chk("d_addr", ramaddr, e.addr);
          if (e.we) chk("d_store", ramstore, e.data); else chk("d_load", dload, e.data);
        end
      end
      if (gnt_i && !iwait) begin
        if (iq.size() == 0) timeout("i_unexpected");
        else begin
          e = iq.pop_front();
          chk("i_addr", ramaddr, e.addr);
          chk("i_load", iload, e.data);
        end
      end
      if (p_idle && p_ireq && m_cnt == SMAX) chk("starve_force", 32'(gnt_i), 1);
    end
    if (RST) m_cnt = 0;
    else if (gnt_d && !dwait) m_cnt = !iREN ? 0 : (m_cnt < SMAX) ? m_cnt + 1 : SMAX;
    else if (gnt_i && !iwait) m_cnt = 0;
    p_idle = !gnt_i && !gnt_d;
    p_ireq = iREN;
  end

  initial begin
    int n;
    #1 RST = 1; iREN = 1; dREN = 1;
    smp();
    chk("rst_ren", 32'(ramREN), 0); chk("rst_wen", 32'(ramWEN), 0);
    chk("rst_iwait", 32'(iwait), 1); chk("rst_dwait", 32'(dwait), 1);
    chk("rst_err", 32'(err), 0); chk("rst_gnt", 32'({gnt_i, gnt_d}), 0);
    chk("rst_addr", ramaddr, 0);
    tick(); iREN = 0; dREN = 0; RST = 0;
    tick(); rs_dir = BUSY; ram_ld = 32'h8C01_0004; iREN = 1; iaddr = 32'h40;
    smp(); chk("f0_gnt", 32'(gnt_i), 0);
    tick(); smp();
    chk("f1_gnt", 32'(gnt_i), 1); chk("f1_addr", ramaddr, 32'h40);
    chk("f1_ren", 32'(ramREN), 1); chk("f1_wait", 32'(iwait), 1);
    tick(); smp(); chk("f2_addr", ramaddr, 32'h40); chk("f2_wait", 32'(iwait), 1);
    tick(); rs_dir = ACCESS; smp();
    chk("f3_wait", 32'(iwait), 0); chk("f3_load", iload, 32'h8C01_0004);
    tick(); iREN = 0; rs_dir = BUSY;
    iREN = 1; iaddr = 32'h44; dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    smp(); chk("s0_idle", 32'({gnt_i, gnt_d}), 0);
    tick(); smp();
    chk("s_gnt_d", 32'(gnt_d), 1); chk("s_wen", 32'(ramWEN), 1); chk("s_ren", 32'(ramREN), 0);
    chk("s_store", ramstore, 32'hDEAD_BEEF); chk("s_addr", ramaddr, 32'h100);
    chk("s_iwait", 32'(iwait), 1); chk("s_dload_ungranted", iload, 0);
    tick(); rs_dir = ACCESS; smp(); chk("s_dwait", 32'(dwait), 0);
    tick(); dWEN = 0; dREN = 0; rs_dir = BUSY; smp(); chk("s_idle", 32'({gnt_i, gnt_d}), 0);
    tick(); smp(); chk("s_gnt_i", 32'(gnt_i), 1); chk("s_iaddr", ramaddr, 32'h44);
    tick(); rs_dir = ACCESS; smp(); chk("s_iwait_done", 32'(iwait), 0);
    tick(); iREN = 0;
    iREN = 1; dREN = 1;
    count_d(n); chk("starve_first", 32'(n), SMAX);
    count_d(n); chk("starve_after_fetch", 32'(n), SMAX);
    tick(); tick(); tick(); rs_dir = BUSY;
    tick(); smp(); chk("drop_pre_gnt", 32'(gnt_d), 1); chk("drop_pre_ren", 32'(ramREN), 1);
    tick(); dREN = 0; smp();
    chk("drop_ren", 32'(ramREN), 0); chk("drop_still_dgnt", 32'(gnt_d), 1);
    tick(); dREN = 1; rs_dir = ACCESS; smp(); chk("drop_idle", 32'({gnt_i, gnt_d}), 0);
    count_d(n); chk("drop_starve_kept", 32'(n), SMAX - 1);
    tick(); iREN = 0; dREN = 0; rs_dir = BUSY;
    iREN = 1; iaddr = 32'h48;
    tick(); smp(); chk("e_gnt", 32'(gnt_i), 1); chk("e_err0", 32'(err), 0);
    tick(); rs_dir = ERROR; ram_ld = 32'h1234; smp();
    chk("e_iwait", 32'(iwait), 0); chk("e_iload", iload, 32'h1234);
    tick(); iREN = 0; rs_dir = BUSY; smp(); chk("e_err", 32'(err), 1);
    repeat (3) tick(); smp(); chk("e_hold", 32'(err), 1);
    tick(); RST = 1; smp(); chk("e_rst", 32'(err), 0);
    tick(); RST = 0; rnd = 1;
    fork drv_d(); drv_i(); join
    repeat (5) tick();
    chk("dq_empty", 32'(dq.size()), 0); chk("iq_empty", 32'(iq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
